// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES types and helpers for the AES-128 datapath blocks.
//   aes_state_t : 128-bit state, column-major, byte 0 in bits [127:120]
//   aes_byte_t  : one state byte
//   AES_NB      : number of columns in the state
//   aes_idx()   : maps (row, col) to the byte index 4*col + row
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    localparam int AES_NB = 4;

    function automatic int aes_idx(input logic [1:0] row, input logic [1:0] col);
        return 4 * int'(col) + int'(row);
    endfunction

endpackage

// File: rtl/aes_shift_rows_perm.sv
// -----------------------------------------------------------------------------
// aes_shift_rows_perm
// Combinational ShiftRows byte permutation (pure wiring, no arithmetic).
// Optional feature macro: AES_SHIFT_ROWS_INV_EN (adds i_inv and the inverse
// permutation; forward mapping is identical in both builds).
// Ports:
//   i_state : input  state, column-major
//   i_inv   : 1 selects InvShiftRows (only with AES_SHIFT_ROWS_INV_EN)
//   o_state : permuted state, column-major
// -----------------------------------------------------------------------------
module aes_shift_rows_perm
    import aes_pkg::*;
(
    input  aes_state_t i_state,
`ifdef AES_SHIFT_ROWS_INV_EN
    input  logic       i_inv,
`endif
    output aes_state_t o_state
);

    aes_state_t w_fwd;
`ifdef AES_SHIFT_ROWS_INV_EN
    aes_state_t w_inv;
`endif

    for (genvar r = 0; r < AES_NB; r++) begin : g_row
        for (genvar c = 0; c < AES_NB; c++) begin : g_col
            localparam logic [1:0] R    = 2'(r);
            localparam logic [1:0] C    = 2'(c);
            // 2-bit column arithmetic wraps mod 4 for free.
            localparam logic [1:0] CF   = C + R;
            localparam int         DST  = aes_idx(R, C);
            localparam int         SRCF = aes_idx(R, CF);

            assign w_fwd[127-8*DST -: 8] = i_state[127-8*SRCF -: 8];

`ifdef AES_SHIFT_ROWS_INV_EN
            localparam logic [1:0] CI   = C - R;
            localparam int         SRCI = aes_idx(R, CI);

            assign w_inv[127-8*DST -: 8] = i_state[127-8*SRCI -: 8];
`endif
        end
    end

`ifdef AES_SHIFT_ROWS_INV_EN
    assign o_state = i_inv ? w_inv : w_fwd;
`else
    assign o_state = w_fwd;
`endif

endmodule

// File: rtl/aes_shift_rows.sv
// -----------------------------------------------------------------------------
// aes_shift_rows
// Registered AES ShiftRows stage (1-cycle latency, one state per cycle, no
// backpressure). Sits between SubBytes and MixColumns.
// Optional feature macro: AES_SHIFT_ROWS_INV_EN (adds inv port; inv=1 selects
// InvShiftRows per captured state).
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset (clears state_out and out_valid)
//   in_valid  : state_in is valid this cycle
//   inv       : 1 selects InvShiftRows (only with AES_SHIFT_ROWS_INV_EN)
//   state_in  : input state, column-major
//   out_valid : state_out holds a newly transformed state
//   state_out : transformed state, column-major; held while in_valid=0
// -----------------------------------------------------------------------------
module aes_shift_rows
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
`ifdef AES_SHIFT_ROWS_INV_EN
    input  logic       inv,
`endif
    input  aes_state_t state_in,
    output logic       out_valid,
    output aes_state_t state_out
);

    aes_state_t w_perm;
    aes_state_t r_state;
    logic       r_valid;

    aes_shift_rows_perm u_perm (
        .i_state (state_in),
`ifdef AES_SHIFT_ROWS_INV_EN
        .i_inv   (inv),
`endif
        .o_state (w_perm)
    );

    // Register stage: capture only on valid so the output holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_state <= w_perm;
            end
        end
    end

    assign state_out = r_state;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_aes_shift_rows.sv
// -----------------------------------------------------------------------------
// tb_aes_shift_rows
// Self-checking bench for aes_shift_rows against a row/column reference model.
// Works in both builds; define AES_SHIFT_ROWS_INV_EN to exercise the inverse.
// -----------------------------------------------------------------------------
module tb_aes_shift_rows;

`ifdef AES_SHIFT_ROWS_INV_EN
    localparam bit HAS_INV = 1'b1;
`else
    localparam bit HAS_INV = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         inv_s;
    logic [127:0] state_in;
    logic         out_valid;
    logic [127:0] state_out;

    int errors;
    int checks;

    aes_shift_rows dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
`ifdef AES_SHIFT_ROWS_INV_EN
        .inv       (inv_s),
`endif
        .state_in  (state_in),
        .out_valid (out_valid),
        .state_out (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unpack into a 4x4 matrix s[r][c] = b[r+4c], rotate each row.
    function automatic logic [127:0] ref_sr(input logic [127:0] s, input bit inv_req);
        logic [7:0]   m [4][4];
        logic [7:0]   o [4][4];
        logic [127:0] res;
        bit           do_inv;
        do_inv = inv_req & HAS_INV;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = s[127 - 8*(r + 4*c) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r][c] = do_inv ? m[r][(c - r + 4) % 4] : m[r][(c + r) % 4];
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127 - 8*(r + 4*c) -: 8] = o[r][c];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Apply inputs, then wait for the capture edge and settle past it.
    task automatic cycle(input logic v, input logic [127:0] s, input logic iv);
        in_valid = v;
        state_in = s;
        inv_s    = iv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        state_in = '0;
        inv_s    = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || state_out !== 128'h0) begin
            errors++;
            $display("FAIL reset: got valid=%b state=%h, want valid=0 state=0", out_valid, state_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_forward_vector();
        cycle(1'b1, 128'h00112233445566778899AABBCCDDEEFF, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || state_out !== 128'h0055AAFF4499EE3388DD2277CC1166BB) begin
            errors++;
            $display("FAIL fwd_vector: got valid=%b state=%h, want valid=1 state=0055aaff4499ee3388dd2277cc1166bb",
                     out_valid, state_out);
        end
    endtask

    task automatic test_inverse_vector();
        if (HAS_INV) begin
            cycle(1'b1, 128'h0055AAFF4499EE3388DD2277CC1166BB, 1'b1);
            checks++;
            if (out_valid !== 1'b1 || state_out !== 128'h00112233445566778899AABBCCDDEEFF) begin
                errors++;
                $display("FAIL inv_vector: got valid=%b state=%h, want valid=1 state=00112233445566778899aabbccddeeff",
                         out_valid, state_out);
            end
        end
    endtask

    task automatic test_single_byte();
        cycle(1'b1, 128'hFF000000000000000000000000000000, 1'b0);
        checks++;
        if (state_out !== 128'hFF000000000000000000000000000000) begin
            errors++;
            $display("FAIL row0_invariant: got %h, want ff000000000000000000000000000000", state_out);
        end
        cycle(1'b1, 128'h00110000000000000000000000000000, 1'b0);
        checks++;
        if (state_out !== 128'h00000000000000000000000000110000) begin
            errors++;
            $display("FAIL byte1_to_13: got %h, want 00000000000000000000000000110000", state_out);
        end
        // Every single byte position, forward direction.
        for (int k = 0; k < 16; k++) begin
            logic [127:0] s;
            s = '0;
            s[127 - 8*k -: 8] = 8'(k + 1);
            cycle(1'b1, s, 1'b0);
            checks++;
            if (state_out !== ref_sr(s, 1'b0)) begin
                errors++;
                $display("FAIL byte_track k=%0d: got %h, want %h", k, state_out, ref_sr(s, 1'b0));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [127:0] s;
            logic         iv;
            s  = rand128();
            iv = 1'($urandom_range(0, 1));
            cycle(1'b1, s, iv);
            checks++;
            if (out_valid !== 1'b1 || state_out !== ref_sr(s, iv)) begin
                errors++;
                $display("FAIL random i=%0d inv=%b: got valid=%b state=%h, want valid=1 state=%h",
                         i, iv, out_valid, state_out, ref_sr(s, iv));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] s [3];
        for (int i = 0; i < 3; i++) s[i] = rand128();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, s[i], 1'(i % 2));
            checks++;
            if (out_valid !== 1'b1 || state_out !== ref_sr(s[i], 1'(i % 2))) begin
                errors++;
                $display("FAIL back_to_back i=%0d: got valid=%b state=%h, want valid=1 state=%h",
                         i, out_valid, state_out, ref_sr(s[i], 1'(i % 2)));
            end
        end
    endtask

    task automatic test_hold();
        logic [127:0] s;
        logic [127:0] held;
        s = rand128();
        cycle(1'b1, s, 1'b0);
        held = ref_sr(s, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, rand128(), 1'($urandom_range(0, 1)));
            checks++;
            if (out_valid !== 1'b0 || state_out !== held) begin
                errors++;
                $display("FAIL hold i=%0d: got valid=%b state=%h, want valid=0 state=%h",
                         i, out_valid, state_out, held);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [127:0] s;
        cycle(1'b1, rand128(), 1'b0);
        // Now 1 ns after the edge with out_valid=1; assert reset mid-cycle.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || state_out !== 128'h0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b state=%h, want valid=0 state=0", out_valid, state_out);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        s = rand128();
        cycle(1'b1, s, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || state_out !== ref_sr(s, 1'b1)) begin
            errors++;
            $display("FAIL after_reset: got valid=%b state=%h, want valid=1 state=%h",
                     out_valid, state_out, ref_sr(s, 1'b1));
        end
        cycle(1'b0, '0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_idle: got valid=%b, want 0", out_valid);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_forward_vector();
        test_inverse_vector();
        test_single_byte();
        test_random();
        test_back_to_back();
        test_hold();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_shift_rows.md
# aes_shift_rows

Registered AES ShiftRows stage for the AES-128 encryption datapath. It sits between SubBytes and MixColumns. It applies the FIPS-197 cyclic row rotation to a 128-bit state presented in column-major byte order. An optional compile-time inverse mode (InvShiftRows) lets the same block serve the decryption datapath.

## Interface
- No parameters; the state width is fixed at 128 bits.
- clk — input, 1 — rising-edge clock.
- rst_n — input, 1 — reset, asynchronous, active-low.
- in_valid — input, 1 — state_in carries a valid state this cycle.
- inv — input, 1 — 1 selects InvShiftRows. Present only when AES_SHIFT_ROWS_INV_EN is defined.
- state_in — input, 128 — input state, column-major.
- out_valid — output, 1 — state_out holds a newly transformed state.
- state_out — output, 128 — transformed state, column-major.

## Operation
- Byte numbering:
  - b[k] = state_in[127-8k -: 8], for k = 0..15; byte 0 is the MSB.
  - State element s[r][c] = b[r + 4c], with row r and column c in 0..3.
- Forward ShiftRows: out[r][c] = s[r][(c + r) mod 4]. Row 0 is unchanged; rows 1, 2, 3 rotate left by 1, 2, 3 byte positions.
- Inverse ShiftRows (inv=1): out[r][c] = s[r][(c − r) mod 4], i.e. rotate right by r.
- The mod-4 column index wraps naturally; use 2-bit column arithmetic.
- The transform is a pure byte permutation:
  - no arithmetic;
  - no dependence on byte values;
  - the same permutation for every input.
- The datapath has no backpressure; the block is always ready.

## Timing
- Latency is exactly 1 cycle.
- On a rising clk edge with in_valid=1:
  - state_out ← transform(state_in), using inv sampled on the same edge;
  - out_valid ← 1.
- On a rising edge with in_valid=0:
  - out_valid ← 0;
  - state_out holds its previous value.
- Throughput is one state per cycle; back-to-back valids each produce a result on consecutive cycles.
- Reset (rst_n=0) takes effect immediately, with no clock needed:
  - state_out = 128'h0;
  - out_valid = 0.
- Reset asserted mid-stream discards any in-flight state.
- First capture after reset: the first rising edge with rst_n=1 and in_valid=1.
- inv may change every cycle. Each captured state uses the inv value present on its own capture edge.

## Configuration
- Macro: AES_SHIFT_ROWS_INV_EN.
- When defined:
  - the inv port exists;
  - the output mux selects the forward or inverse permutation per cycle.
- When undefined:
  - the inv port is absent;
  - only the forward permutation is built.
- Forward behaviour is bit-identical in both builds.

## Structure
- Shared package aes_pkg holds:
  - typedef aes_state_t (logic [127:0]);
  - typedef aes_byte_t (logic [7:0]);
  - constant AES_NB = 4;
  - a function mapping (row, col) to a byte index: 4*col + row.
- One combinational sub-module, aes_shift_rows_perm:
  - inputs: state, and inv when configured;
  - output: the permuted state.
  - It is built as generate loops over r and c.
- The top level is the register stage plus valid tracking.

## Test plan
- Forward vector: state_in=00112233445566778899AABBCCDDEEFF, in_valid=1 → one cycle later state_out=0055AAFF4499EE3388DD2277CC1166BB, out_valid=1.
- Inverse vector (AES_SHIFT_ROWS_INV_EN, inv=1): state_in=0055AAFF4499EE3388DD2277CC1166BB → state_out=00112233445566778899AABBCCDDEEFF.
- Row-0 invariance and single-byte tracking: state_in=FF000000000000000000000000000000 → output unchanged. state_in with 0x11 at byte 1 only (000000… value 0011000000…) → 0x11 appears at byte 13.
- Back-to-back: three consecutive valid states with alternating inv → three correct results on three consecutive cycles, in order.
- Hold behaviour: in_valid deasserted for 2 cycles → out_valid=0 and state_out unchanged.
- Asynchronous reset asserted between clock edges while out_valid=1 → state_out=0 and out_valid=0 immediately. After release, the first valid input produces a correct result one cycle later.
